// File: rtl/gray_counter.sv
// Loadable Gray-code pointer counter with a synchronised remote-pointer decoder.
// Define GRAY_COUNTER_UPDOWN_EN to honour dir and build down-counting with down-wrap.
module gray_counter #(
  parameter int DATAWIDTH   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 dir,
  input  logic                 load,
  input  logic [DATAWIDTH-1:0] load_value,
  output logic [DATAWIDTH-1:0] bin_out,
  output logic [DATAWIDTH-1:0] gray_out,
  output logic                 wrap,
  input  logic [DATAWIDTH-1:0] remote_gray_in,
  output logic [DATAWIDTH-1:0] remote_bin_out
);

  logic [DATAWIDTH-1:0] r_bin, r_gray, r_rbin;
  logic                 r_wrap;
  logic [DATAWIDTH-1:0] w_bin_nxt, w_gray_nxt, w_rsync, w_rdec;
  logic                 w_wrap_nxt;

  always_comb begin
    w_bin_nxt  = r_bin;
    w_wrap_nxt = 1'b0;
    if (load) begin
      w_bin_nxt = load_value;
    end else if (en) begin
`ifdef GRAY_COUNTER_UPDOWN_EN
      if (dir) begin
        w_bin_nxt  = r_bin + 1'b1;
        w_wrap_nxt = &r_bin;
      end else begin
        w_bin_nxt  = r_bin - 1'b1;
        w_wrap_nxt = ~|r_bin;
      end
`else
      w_bin_nxt  = r_bin + 1'b1;
      w_wrap_nxt = &r_bin;
`endif
    end
    // Gray is derived from the next binary value so both flops update together.
    w_gray_nxt = w_bin_nxt ^ (w_bin_nxt >> 1);
  end

`ifndef GRAY_COUNTER_UPDOWN_EN
  logic w_unused_dir;
  assign w_unused_dir = dir;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin  <= '0;
      r_gray <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_bin  <= w_bin_nxt;
      r_gray <= w_gray_nxt;
      r_wrap <= w_wrap_nxt;
    end
  end

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_rsync = remote_gray_in;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0][DATAWIDTH-1:0] r_sync;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sync <= '0;
        end else begin
          r_sync[0] <= remote_gray_in;
          for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
        end
      end
      assign w_rsync = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  always_comb begin
    w_rdec = '0;
    w_rdec[DATAWIDTH-1] = w_rsync[DATAWIDTH-1];
    for (int i = DATAWIDTH-2; i >= 0; i--) w_rdec[i] = w_rdec[i+1] ^ w_rsync[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rbin <= '0;
    else        r_rbin <= w_rdec;
  end

  assign bin_out        = r_bin;
  assign gray_out       = r_gray;
  assign wrap           = r_wrap;
  assign remote_bin_out = r_rbin;

endmodule

// File: tb/tb_gray_counter.sv
// Randomised and directed bench for gray_counter against an arithmetic model.
module tb_gray_counter;
  localparam int DW = 4;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0, dir = 1'b1, load = 1'b0;
  logic [DW-1:0] load_value = '0, remote_gray_in = '0;
  logic [DW-1:0] bin_out, gray_out, remote_bin_out;
  logic          wrap;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  gray_counter #(.DATAWIDTH(DW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .load(load),
    .load_value(load_value), .bin_out(bin_out), .gray_out(gray_out),
    .wrap(wrap), .remote_gray_in(remote_gray_in), .remote_bin_out(remote_bin_out)
  );

  always #5 clk = ~clk;

  // Model: integer count modulo 2^DW, and remote value as the input seen SS+1 edges ago.
  int            m_cnt = 0;
  bit            m_wrap = 1'b0;
  logic [DW-1:0] m_hist [0:SS];

  function automatic logic [DW-1:0] g2b(input logic [DW-1:0] g);
    logic [DW-1:0] b;
    for (int i = 0; i < DW; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  <= 0;
      m_wrap <= 1'b0;
      for (int k = 0; k <= SS; k++) m_hist[k] <= '0;
    end else begin
      if (load) begin
        m_cnt  <= int'(load_value);
        m_wrap <= 1'b0;
      end else if (en) begin
`ifdef GRAY_COUNTER_UPDOWN_EN
        if (!dir) begin
          m_cnt  <= (m_cnt == 0) ? (1 << DW) - 1 : m_cnt - 1;
          m_wrap <= (m_cnt == 0);
        end else
`endif
        begin
          m_cnt  <= (m_cnt + 1) % (1 << DW);
          m_wrap <= (m_cnt == (1 << DW) - 1);
        end
      end else begin
        m_wrap <= 1'b0;
      end
      m_hist[0] <= remote_gray_in;
      for (int k = 1; k <= SS; k++) m_hist[k] <= m_hist[k-1];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      logic [DW-1:0] eb;
      eb = DW'(m_cnt);
      chk("model_bin", 32'(bin_out), 32'(eb));
      chk("model_gray", 32'(gray_out), 32'(eb ^ (eb >> 1)));
      chk("model_wrap", 32'(wrap), 32'(m_wrap));
      chk("model_remote", 32'(remote_bin_out), 32'(g2b(m_hist[SS])));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  logic [DW-1:0] gray_tbl [0:15];
  logic [DW-1:0] prev_g;

  initial begin
    gray_tbl = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
    // Reset held with random inputs
    for (int c = 0; c < 4; c++) begin
      en = 1'($urandom); dir = 1'($urandom); load = 1'($urandom);
      load_value = DW'($urandom); remote_gray_in = DW'($urandom);
      step();
      chk("rst_bin", 32'(bin_out), 0);
      chk("rst_gray", 32'(gray_out), 0);
      chk("rst_wrap", 32'(wrap), 0);
      chk("rst_remote", 32'(remote_bin_out), 0);
    end
    load = 1'b0; en = 1'b1; dir = 1'b1; remote_gray_in = '0;
    rst_n = 1'b1;
    chk_on = 1'b1;
    step();
    chk("first_en_bin", 32'(bin_out), 1);
    chk("first_en_gray", 32'(gray_out), 32'b0001);

    // Full up-count from 0
    en = 1'b0; load = 1'b1; load_value = '0;
    step();
    load = 1'b0; en = 1'b1; dir = 1'b1;
    prev_g = gray_out;
    for (int k = 0; k < 16; k++) begin
      step();
      chk("up_gray", 32'(gray_out), 32'(gray_tbl[(k+1)%16]));
      chk("up_onebit", $countones(gray_out ^ prev_g), 1);
      chk("up_wrap", 32'(wrap), (k == 15) ? 1 : 0);
      prev_g = gray_out;
    end
    chk("up_end_bin", 32'(bin_out), 0);

    // Load priority over en
    load = 1'b1; load_value = 4'b1011; en = 1'b1;
    step();
    chk("load_bin", 32'(bin_out), 32'b1011);
    chk("load_gray", 32'(gray_out), 32'b1110);
    chk("load_wrap", 32'(wrap), 0);
    load = 1'b0;
    step();
    chk("load_next_bin", 32'(bin_out), 32'b1100);
    chk("load_next_gray", 32'(gray_out), 32'b1010);

    // Down step from 0
    load = 1'b1; load_value = '0; en = 1'b0;
    step();
    load = 1'b0; en = 1'b1; dir = 1'b0;
    step();
`ifdef GRAY_COUNTER_UPDOWN_EN
    chk("down_bin", 32'(bin_out), 32'b1111);
    chk("down_gray", 32'(gray_out), 32'b1000);
    chk("down_wrap", 32'(wrap), 1);
    en = 1'b0;
    step();
    chk("down_wrap_drop", 32'(wrap), 0);
`else
    chk("down_bin", 32'(bin_out), 32'b0001);
    chk("down_wrap", 32'(wrap), 0);
    en = 1'b0;
`endif
    dir = 1'b1;

    // Remote decode latency
    remote_gray_in = '0;
    for (int c = 0; c < 4; c++) step();
    remote_gray_in = 4'b1110;
    step(); chk("remote_e1", 32'(remote_bin_out), 0);
    step(); chk("remote_e2", 32'(remote_bin_out), 0);
    step(); chk("remote_e3", 32'(remote_bin_out), 32'b1011);
    remote_gray_in = 4'b1010;
    step(); chk("remote2_e1", 32'(remote_bin_out), 32'b1011);
    step(); chk("remote2_e2", 32'(remote_bin_out), 32'b1011);
    step(); chk("remote2_e3", 32'(remote_bin_out), 32'b1100);

    // Asynchronous reset mid-count
    load = 1'b1; load_value = 4'd7;
    step();
    load = 1'b0; en = 1'b0;
    chk("pre_rst_bin", 32'(bin_out), 7);
    rst_n = 1'b0;
    #1;
    chk("async_rst_bin", 32'(bin_out), 0);
    chk("async_rst_gray", 32'(gray_out), 0);
    chk("async_rst_wrap", 32'(wrap), 0);
    chk("async_rst_remote", 32'(remote_bin_out), 0);
    #1;
    rst_n = 1'b1;
    en = 1'b1;
    step();
    chk("restart_bin", 32'(bin_out), 1);

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      load = ($urandom_range(0, 9) == 0);
      en = ($urandom_range(0, 3) != 0);
      dir = 1'($urandom);
      load_value = DW'($urandom);
      if ($urandom_range(0, 3) == 0) remote_gray_in = DW'($urandom);
      step();
    end

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
